// File: rtl/syrk_pkg.sv
// Shared definitions for the SYRK control sequencer.
//   syrk_state_e : sequencer state encoding
//   SYRK_DW      : default data word width
//   syrk_iw()    : bits needed for a row/column/k index (0..n-1)
//   syrk_aw()    : bits needed for a linear buffer address (0..n*n-1)
package syrk_pkg;

  localparam int SYRK_DW = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_ALPHA,
    ST_LD_BETA,
    ST_LD_A,
    ST_LD_C,
    ST_COMPUTE,
    ST_DRAIN,
    ST_OUTPUT,
    ST_DONE
  } syrk_state_e;

  function automatic int syrk_iw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int syrk_aw(input int n);
    return (n < 2) ? 1 : $clog2(n * n);
  endfunction

endpackage

// File: rtl/syrk_index_gen.sv
// Nested i / j / k index counter.
//   TRI=1   : j runs 0..i (lower triangle); TRI=0 : j runs 0..N-1
//   USE_K=0 : innermost k level collapsed (k stays 0, every step is a 'last')
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous return to (0,0,0), overrides step
//   step          advance by one innermost position
//   i, j, k       current indices
//   first / last  k == 0 / k == N-1
//   wrap          current position is the final one; a step now returns to 0
module syrk_index_gen
  import syrk_pkg::*;
#(
  parameter int  N     = 4,
  parameter bit  TRI   = 1'b1,
  parameter bit  USE_K = 1'b1,
  localparam int IW    = syrk_iw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] k,
  output logic          first,
  output logic          last,
  output logic          wrap
);

  localparam logic [IW-1:0] MAX = IW'(N - 1);

  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic          k_last, j_last, i_last;

  assign k_last = USE_K ? (k_q == MAX) : 1'b1;
  assign j_last = TRI ? (j_q == i_q) : (j_q == MAX);
  assign i_last = (i_q == MAX);

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (step) begin
      if (!k_last) begin
        k_d = k_q + 1'b1;
      end else begin
        k_d = '0;
        if (!j_last) begin
          j_d = j_q + 1'b1;
        end else begin
          j_d = '0;
          i_d = i_last ? '0 : i_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i     = i_q;
  assign j     = j_q;
  assign k     = k_q;
  assign first = (k_q == '0);
  assign last  = k_last;
  assign wrap  = i_last & j_last & k_last;

endmodule

// File: rtl/syrk_sequencer.sv
// SYRK control sequencer: parses alpha, beta, A, C from the input stream,
// writes the A/C buffers, walks the lower-triangle i/j/k loop for the MAC
// datapath, schedules accumulator writebacks and streams C out.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       job start pulse (honoured in IDLE / DONE)
//   din, din_valid              input word stream
//   dout_ready                  output handshake (only with SYRK_OUT_READY_EN)
//   wr_data, wr_addr, a_we, c_we  buffer write port
//   alpha_q, beta_q             latched scalars
//   a_raddr0, a_raddr1, c_raddr buffer read addresses
//   mac_en, mac_first, mac_last MAC step controls
//   c_wb, c_wb_addr             accumulator writeback strobe and address
//   dout_valid                  c_rdata carries an output word
//   flag                        job complete (level)
// Build option: SYRK_OUT_READY_EN adds dout_ready backpressure on OUTPUT.
//
// state      | meaning
// -----------+----------------------------------------------
// IDLE       | after reset, waiting for start
// LD_ALPHA   | next valid word is alpha
// LD_BETA    | next valid word is beta
// LD_A       | writing A row-major
// LD_C       | writing C row-major
// COMPUTE    | one MAC step per cycle over lower triangle
// DRAIN      | waiting for the last writeback to land
// OUTPUT     | reading C out, one word per accepted cycle
// DONE       | flag high, waiting for start
module syrk_sequencer
  import syrk_pkg::*;
#(
  parameter int  N       = 100,
  parameter int  DW      = SYRK_DW,
  parameter int  MAC_LAT = 3,
  localparam int AW      = syrk_aw(N),
  localparam int IW      = syrk_iw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
`ifdef SYRK_OUT_READY_EN
  input  logic          dout_ready,
`endif
  output logic [DW-1:0] wr_data,
  output logic          a_we,
  output logic          c_we,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] alpha_q,
  output logic [DW-1:0] beta_q,
  output logic [AW-1:0] a_raddr0,
  output logic [AW-1:0] a_raddr1,
  output logic [AW-1:0] c_raddr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          mac_last,
  output logic          c_wb,
  output logic [AW-1:0] c_wb_addr,
  output logic          dout_valid,
  output logic          flag
);

  localparam int            DCW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT);
  localparam logic [AW-1:0] N_A = AW'(N);

  function automatic logic [AW-1:0] lin(input logic [IW-1:0] r, input logic [IW-1:0] c);
    return AW'(r) * N_A + AW'(c);
  endfunction

  syrk_state_e    state_q, state_d;
  logic [DW-1:0]  alpha_d, beta_q_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic           a_we_q, a_we_d, c_we_q, c_we_d;
  logic           flag_q, flag_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           out_last_q, out_last_d;
  logic           dout_valid_q, dout_valid_d;
  logic [AW-1:0]  out_addr_q, out_addr_d;
  logic           adv, issue;

  // Load / output counter: row-major walk over the full N x N square.
  logic           ld_step, ld_clr, ld_wrap;
  logic [IW-1:0]  ld_i, ld_j, ld_k_unused;
  logic           ld_first_unused, ld_last_unused;
  logic [AW-1:0]  ld_addr;

  // Compute counter: i, j<=i, k.
  logic           cm_step, cm_clr, cm_wrap, cm_first, cm_last;
  logic [IW-1:0]  cm_i, cm_j, cm_k;
  logic [AW-1:0]  pair_addr;

  // Writeback delay line: mac_last plus the pair address, MAC_LAT deep.
  logic [MAC_LAT-1:0] wb_vld_q, wb_vld_d;
  logic [AW-1:0]      wb_addr_q [MAC_LAT];
  logic [AW-1:0]      wb_addr_d [MAC_LAT];

  syrk_index_gen #(.N(N), .TRI(1'b0), .USE_K(1'b0)) u_ld_idx (
    .clk   (clk),
    .rst   (rst),
    .clr   (ld_clr),
    .step  (ld_step),
    .i     (ld_i),
    .j     (ld_j),
    .k     (ld_k_unused),
    .first (ld_first_unused),
    .last  (ld_last_unused),
    .wrap  (ld_wrap)
  );

  syrk_index_gen #(.N(N), .TRI(1'b1), .USE_K(1'b1)) u_cm_idx (
    .clk   (clk),
    .rst   (rst),
    .clr   (cm_clr),
    .step  (cm_step),
    .i     (cm_i),
    .j     (cm_j),
    .k     (cm_k),
    .first (cm_first),
    .last  (cm_last),
    .wrap  (cm_wrap)
  );

  assign ld_addr   = lin(ld_i, ld_j);
  assign pair_addr = lin(cm_i, cm_j);
  assign ld_clr    = !(state_q inside {ST_LD_A, ST_LD_C, ST_OUTPUT});
  assign cm_clr    = (state_q != ST_COMPUTE);
  assign cm_step   = (state_q == ST_COMPUTE);

`ifdef SYRK_OUT_READY_EN
  // A presented word is retired only when the consumer takes it.
  assign adv = ~dout_valid_q | dout_ready;
`else
  assign adv = 1'b1;
`endif
  assign issue = (state_q == ST_OUTPUT) && !out_last_q && adv;

  always_comb begin
    state_d      = state_q;
    alpha_d      = alpha_q;
    beta_q_d     = beta_q;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    a_we_d       = 1'b0;
    c_we_d       = 1'b0;
    flag_d       = flag_q;
    drain_d      = drain_q;
    out_last_d   = out_last_q;
    dout_valid_d = dout_valid_q;
    out_addr_d   = out_addr_q;
    ld_step      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LD_ALPHA;
          flag_d  = 1'b0;
        end
      end
      ST_LD_ALPHA: begin
        if (din_valid) begin
          alpha_d = din;
          state_d = ST_LD_BETA;
        end
      end
      ST_LD_BETA: begin
        if (din_valid) begin
          beta_q_d = din;
          state_d  = ST_LD_A;
        end
      end
      ST_LD_A, ST_LD_C: begin
        if (din_valid) begin
          ld_step   = 1'b1;
          wr_data_d = din;
          wr_addr_d = ld_addr;
          if (state_q == ST_LD_A) a_we_d = 1'b1;
          else                    c_we_d = 1'b1;
          if (ld_wrap) state_d = (state_q == ST_LD_A) ? ST_LD_C : ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (cm_wrap) begin
          state_d = ST_DRAIN;
          drain_d = DCW'(MAC_LAT - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d      = ST_OUTPUT;
          out_last_d   = 1'b0;
          dout_valid_d = 1'b0;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (adv) begin
          // Extra cycle after the last address presents the final word.
          dout_valid_d = !out_last_q;
          if (!out_last_q) begin
            ld_step    = 1'b1;
            out_addr_d = ld_addr;
            if (ld_wrap) out_last_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            flag_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_vld_d     = '0;
    wb_vld_d[0]  = mac_last;
    wb_addr_d[0] = pair_addr;
    for (int s = 1; s < MAC_LAT; s++) begin
      wb_vld_d[s]  = wb_vld_q[s-1];
      wb_addr_d[s] = wb_addr_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alpha_q      <= '0;
      beta_q       <= '0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      a_we_q       <= 1'b0;
      c_we_q       <= 1'b0;
      flag_q       <= 1'b0;
      drain_q      <= '0;
      out_last_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      out_addr_q   <= '0;
      wb_vld_q     <= '0;
      for (int s = 0; s < MAC_LAT; s++) wb_addr_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      alpha_q      <= alpha_d;
      beta_q       <= beta_q_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      a_we_q       <= a_we_d;
      c_we_q       <= c_we_d;
      flag_q       <= flag_d;
      drain_q      <= drain_d;
      out_last_q   <= out_last_d;
      dout_valid_q <= dout_valid_d;
      out_addr_q   <= out_addr_d;
      wb_vld_q     <= wb_vld_d;
      wb_addr_q    <= wb_addr_d;
    end
  end

  assign wr_data    = wr_data_q;
  assign wr_addr    = wr_addr_q;
  assign a_we       = a_we_q;
  assign c_we       = c_we_q;
  assign flag       = flag_q;
  assign dout_valid = dout_valid_q;

  assign mac_en     = (state_q == ST_COMPUTE);
  assign mac_first  = mac_en & cm_first;
  assign mac_last   = mac_en & cm_last;
  assign a_raddr0   = mac_en ? lin(cm_i, cm_k) : '0;
  assign a_raddr1   = mac_en ? lin(cm_j, cm_k) : '0;
  // While a word is stalled, keep reading its address so c_rdata holds.
  assign c_raddr    = mac_en ? pair_addr :
                      (state_q == ST_OUTPUT) ? (issue ? ld_addr : out_addr_q) : '0;

  assign c_wb       = wb_vld_q[MAC_LAT-1];
  assign c_wb_addr  = wb_addr_q[MAC_LAT-1];

endmodule

// File: tb/tb_syrk_sequencer.sv
// Directed bench for syrk_sequencer at N=4, MAC_LAT=3 with a behavioural
// buffer/MAC datapath hung off the sequencer outputs.
module tb_syrk_sequencer;

  logic        clk, rst, start, din_valid;
  logic [31:0] din, wr_data, alpha_q, beta_q;
  logic        a_we, c_we, mac_en, mac_first, mac_last, c_wb, dout_valid, flag;
  logic [3:0]  wr_addr, a_raddr0, a_raddr1, c_raddr, c_wb_addr;
  logic        dout_acc;
`ifdef SYRK_OUT_READY_EN
  logic        dout_ready;
`endif

  syrk_sequencer #(.N(4), .DW(32), .MAC_LAT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
`ifdef SYRK_OUT_READY_EN
    .dout_ready (dout_ready),
`endif
    .wr_data    (wr_data),
    .a_we       (a_we),
    .c_we       (c_we),
    .wr_addr    (wr_addr),
    .alpha_q    (alpha_q),
    .beta_q     (beta_q),
    .a_raddr0   (a_raddr0),
    .a_raddr1   (a_raddr1),
    .c_raddr    (c_raddr),
    .mac_en     (mac_en),
    .mac_first  (mac_first),
    .mac_last   (mac_last),
    .c_wb       (c_wb),
    .c_wb_addr  (c_wb_addr),
    .dout_valid (dout_valid),
    .flag       (flag)
  );

`ifdef SYRK_OUT_READY_EN
  assign dout_acc = dout_valid & dout_ready;
`else
  assign dout_acc = dout_valid;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed results: lower triangle 30 + (j+1), upper as loaded (j+1).
  logic [31:0] exp_dout [16] = '{31, 2, 3, 4, 31, 32, 3, 4, 31, 32, 33, 4, 31, 32, 33, 34};
  logic [31:0] exp_wb   [10] = '{0, 4, 5, 8, 9, 10, 12, 13, 14, 15};

  // Datapath model: buffers with 1-cycle read, MAC, writeback.
  logic [31:0] amem [16];
  logic [31:0] cmem [16];
  logic [31:0] c_rdata, acc, acc_n;
  logic [31:0] pq [$];

  always @(posedge clk) begin
    if (rst) begin
      pq.delete();
    end else begin
      if (a_we) amem[wr_addr] <= wr_data;
      if (c_we) cmem[wr_addr] <= wr_data;
      if (c_wb && pq.size() > 0) begin
        cmem[c_wb_addr] <= alpha_q * pq[0] + beta_q * cmem[c_wb_addr];
        void'(pq.pop_front());
      end
      if (mac_en) begin
        acc_n = (mac_first ? 32'd0 : acc) + amem[a_raddr0] * amem[a_raddr1];
        acc <= acc_n;
        if (mac_last) pq.push_back(acc_n);
      end
    end
    c_rdata <= cmem[c_raddr];
  end

  // Per-cycle monitor.
  int cyc = 0;
  int a_cnt, c_cnt, mac_cnt, ml_cnt, wb_cnt, out_cnt;
  int lq [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_we) begin
      check("a_addr", wr_addr, a_cnt);
      check("a_data", wr_data, a_cnt % 4 + 1);
      a_cnt++;
    end
    if (c_we) begin
      check("c_addr", wr_addr, c_cnt);
      check("c_data", wr_data, c_cnt % 4 + 1);
      c_cnt++;
    end
    if (mac_en) mac_cnt++;
    if (mac_last) begin
      lq.push_back(cyc);
      ml_cnt++;
    end
    if (c_wb) begin
      check("wb_pending", lq.size(), 1);
      if (lq.size() > 0) check("wb_lat", cyc - lq.pop_front(), 3);
      if (wb_cnt < 10) check("wb_addr", c_wb_addr, exp_wb[wb_cnt]);
      else             check("wb_extra", wb_cnt, 9);
      wb_cnt++;
    end
    if (dout_acc) begin
      check("flag_early", flag, 0);
      if (out_cnt < 16) check("dout", c_rdata, exp_dout[out_cnt]);
      else              check("dout_extra", out_cnt, 15);
      out_cnt++;
    end
  end

  task automatic send(input logic [31:0] w, input bit gap);
    if (gap) begin
      din       = 32'hdead_beef;
      din_valid = 1'b0;
      tick();
    end
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic start_job();
    a_cnt = 0; c_cnt = 0; mac_cnt = 0; ml_cnt = 0; wb_cnt = 0; out_cnt = 0;
    lq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("flag_clr", flag, 0);
  endtask

  task automatic load_words(input bit gap, input bit pokes);
    send(32'd1, gap);
    send(32'd1, gap);
    for (int n = 0; n < 16; n++) begin
      start = pokes && (n == 5);
      send(n % 4 + 1, gap);
      start = 1'b0;
    end
    for (int n = 0; n < 16; n++) send(n % 4 + 1, gap);
  endtask

  task automatic run_job(input bit gap, input bit pokes);
    int lim;
    bit done_seen;
    start_job();
    load_words(gap, pokes);
    din       = 32'h0000_0077;
    din_valid = 1'b1;
    lim       = 0;
    done_seen = 1'b0;
    while (!done_seen && lim < 400) begin
      start = pokes && dout_valid && (out_cnt == 5 || out_cnt == 15);
      tick();
      lim++;
      if (flag) done_seen = 1'b1;
    end
    start     = 1'b0;
    din_valid = 1'b0;
    check("reach_done", done_seen, 1);
    check("alpha", alpha_q, 1);
    check("beta", beta_q, 1);
    check("a_writes", a_cnt, 16);
    check("c_writes", c_cnt, 16);
    check("mac_cycles", mac_cnt, 40);
    check("wb_count", wb_cnt, 10);
    check("out_words", out_cnt, 16);
    repeat (3) tick();
    check("flag_hold", flag, 1);
  endtask

  initial begin
    int lim;
    int wb_seen;
    rst = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0;
`ifdef SYRK_OUT_READY_EN
    dout_ready = 1'b1;
`endif
    repeat (3) tick();
    check("rst_a_we", a_we, 0);
    check("rst_c_we", c_we, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_c_wb", c_wb, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_flag", flag, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_alpha", alpha_q, 0);
    check("rst_beta", beta_q, 0);
    check("rst_c_raddr", c_raddr, 0);
    check("rst_a_raddr0", a_raddr0, 0);
    rst = 1'b0;
    tick();

    // Words while IDLE must be ignored.
    din = 32'h55; din_valid = 1'b1;
    tick();
    tick();
    din_valid = 1'b0;
    check("idle_no_we", a_we | c_we, 0);

    run_job(1'b0, 1'b0);
    run_job(1'b1, 1'b1);

    // Reset during COMPUTE, right at the second pair's last k step.
    start_job();
    load_words(1'b0, 1'b0);
    lim = 0;
    while (!(mac_last && ml_cnt == 1) && lim < 100) begin
      tick();
      lim++;
    end
    check("reach_compute", mac_last, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lq.delete();
    check("abort_mac_en", mac_en, 0);
    check("abort_we", a_we | c_we, 0);
    check("abort_flag", flag, 0);
    check("abort_c_wb", c_wb, 0);
    wb_seen = 0;
    repeat (5) begin
      tick();
      wb_seen += int'(c_wb);
    end
    check("abort_wb_drop", wb_seen, 0);

    run_job(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

`ifdef SYRK_OUT_READY_EN
  // Hold dout_ready low for 5 cycles while word 3 is presented.
  initial begin
    logic [31:0] held;
    bit found;
    found = 1'b0;
    for (int w = 0; w < 3000 && !found; w++) begin
      tick();
      if (dout_valid && out_cnt == 3) found = 1'b1;
    end
    check("stall_reach", found, 1);
    if (found) begin
      dout_ready = 1'b0;
      held = c_rdata;
      check("stall_word", held, exp_dout[3]);
      repeat (5) begin
        tick();
        check("stall_valid", dout_valid, 1);
        check("stall_data", c_rdata, held);
      end
      dout_ready = 1'b1;
    end
  end
`endif

endmodule
